// File: rtl/prog_uart_rx.sv
`default_nettype none
// ==========================================================================
// prog_uart_rx : 8N1 UART receiver with valid/ready byte output.
// Define PROG_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
// Revision: 1.0
// ==========================================================================
module prog_uart_rx #(
  parameter int CLK_DIV    = 78,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rx_sync1, rx_sync2, rx_prev;
  logic [1:0]    settle;
  logic          armed;
  logic          fall, cnt_zero, push, ferr_set;
  logic          pop, full, accept;

  // Edges count only once the line has been seen high after reset, so a frame
  // already running at release cannot masquerade as a start bit.
  assign fall     = armed & rx_prev & ~rx_sync2;
  assign cnt_zero = (cnt == '0);
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync1    <= 1'b1;
      rx_sync2    <= 1'b1;
      rx_prev     <= 1'b1;
      settle      <= 2'b00;
      armed       <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      frame_err_o <= 1'b0;
    end else begin
      rx_sync1    <= rx_i;
      rx_sync2    <= rx_sync1;
      rx_prev     <= rx_sync2;
      settle      <= {settle[0], 1'b1};
      armed       <= armed | (settle[1] & rx_sync2);
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shreg       <= shreg_nxt;
      frame_err_o <= ferr_set;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!rx_sync2) begin
          state_nxt = DATA;
          cnt_nxt   = BIT_LOAD;
          idx_nxt   = 3'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shreg_nxt = {rx_sync2, shreg[7:1]};
          cnt_nxt   = BIT_LOAD;
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_sync2) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr_set  = 1'b1;
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_sync2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A push into a full buffer still lands when the head leaves in the same cycle.
  assign pop    = byte_valid_o & byte_ready_i;
  assign accept = push & (~full | pop);

`ifdef PROG_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign byte_valid_o = (count != '0);
  assign byte_o       = byte_valid_o ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= push & ~accept;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= shreg;
  end
`else
  logic [7:0] hold;
  logic       hold_valid;
  logic       unused_depth;

  assign unused_depth = (FIFO_DEPTH > 0);
  assign full         = hold_valid;
  assign byte_valid_o = hold_valid;
  assign byte_o       = hold;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold       <= 8'h00;
      hold_valid <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= push & ~accept;
      if (accept) begin
        hold       <= shreg;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_uart_rx.sv
`default_nettype none
// tb_prog_uart_rx : directed 8N1 frames checked cycle by cycle against a queue model
// of the receive path and byte buffer.
module tb_prog_uart_rx;

  localparam int CLK_DIV = 78;
`ifdef PROG_RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif
  // Line falls -> byte visible: 2 sync flops + edge detect, half a bit, then 9 bit times.
  localparam int LAT = 3 + CLK_DIV / 2 + 9 * CLK_DIV;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] byte_o;
  logic       valid, ferr, ovr, busy;

  always #5 clk = ~clk;

  prog_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_i         (rx),
    .byte_o       (byte_o),
    .byte_valid_o (valid),
    .byte_ready_i (ready),
    .frame_err_o  (ferr),
    .overrun_o    (ovr),
    .busy_o       (busy)
  );

  int         checks = 0, failures = 0;
  int         cyc = 0;
  int         ev_cyc[$];
  logic [8:0] ev_dat[$];
  int         ev_rd = 0;
  logic [7:0] mq[$];
  logic [7:0] hs_log[$];
  bit         exp_ferr = 0, exp_ovr = 0, prev_valid = 0;
  int         n_vcyc = 0, n_ferr = 0, n_ovr = 0;
  int         vrise_cyc = -1, ferr_cyc = -1, ovr_cyc = -1;
  int         s, h0, o0, f0, v0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: bytes land in a bounded queue at the expected cycle; the head leaves on a handshake.
  task automatic model_step();
    cyc++;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && ready) void'(mq.pop_front());
      while (ev_rd < ev_cyc.size() && ev_cyc[ev_rd] <= cyc) begin
        if (ev_cyc[ev_rd] == cyc) begin
          if (ev_dat[ev_rd][8])     exp_ferr = 1'b1;
          else if (mq.size() < CAP) mq.push_back(ev_dat[ev_rd][7:0]);
          else                      exp_ovr = 1'b1;
        end
        ev_rd++;
      end
    end
  endtask

  task automatic compare_step();
    if (!rst_n) begin
      chk("rst_valid", valid, 0);
      chk("rst_byte", byte_o, 0);
      chk("rst_ferr", ferr, 0);
      chk("rst_ovr", ovr, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("valid", valid, mq.size() != 0);
      if (valid && mq.size() != 0) chk("byte", byte_o, mq[0]);
      chk("frame_err", ferr, exp_ferr);
      chk("overrun", ovr, exp_ovr);
      if (valid) n_vcyc++;
      if (valid && ready) hs_log.push_back(byte_o);
      if (ferr) begin n_ferr++; ferr_cyc = cyc; end
      if (ovr)  begin n_ovr++;  ovr_cyc  = cyc; end
      if (valid && !prev_valid) vrise_cyc = cyc;
    end
    prev_valid = valid;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rdy_pulse,
                            output int start);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    start = cyc;
    ev_cyc.push_back(start + LAT);
    ev_dat.push_back({~stop_ok, b});
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      rx = fr[k / CLK_DIV];
      if (rdy_pulse && k == LAT - 1) ready = 1'b1;
      if (rdy_pulse && k == LAT)     ready = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin @(posedge clk); model_step(); end
      forever begin @(negedge clk); compare_step(); end
    join_none

    // Reset values
    wait_cycles(3);
    chk("reset_valid", valid, 0);
    chk("reset_byte", byte_o, 8'h00);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    wait_cycles(10);

    // 'T' with consumer always ready: one-cycle valid at the literal latency
    v0 = n_vcyc; h0 = hs_log.size();
    send_frame(8'h54, 1'b1, 1'b0, s);
    wait_cycles(5);
    chk("t_latency", vrise_cyc - s, 744);
    chk("t_valid_cycles", n_vcyc - v0, 1);
    chk("t_handshakes", hs_log.size() - h0, 1);
    chk("t_byte", hs_log[hs_log.size()-1], 8'h54);
    chk("t_no_err", n_ferr + n_ovr, 0);

    // 20-cycle low glitch is a false start
    h0 = hs_log.size();
    rx = 1'b0;
    wait_cycles(5);
    chk("glitch_busy_hi", busy, 1);
    wait_cycles(15);
    rx = 1'b1;
    wait_cycles(60);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_no_byte", hs_log.size() - h0, 0);
    chk("glitch_no_err", n_ferr, 0);

    // Framing error followed by a long break, then a clean byte
    f0 = n_ferr; h0 = hs_log.size();
    send_frame(8'hA5, 1'b0, 1'b0, s);
    wait_cycles(2000);
    chk("break_one_ferr", n_ferr - f0, 1);
    chk("break_ferr_time", ferr_cyc - s, 744);
    chk("break_busy", busy, 1);
    chk("break_no_byte", hs_log.size() - h0, 0);
    rx = 1'b1;
    wait_cycles(10);
    chk("break_idle", busy, 0);
    send_frame(8'h3C, 1'b1, 1'b0, s);
    wait_cycles(5);
    chk("after_break_byte", hs_log[hs_log.size()-1], 8'h3C);
    chk("after_break_count", hs_log.size() - h0, 1);

    // Fill the buffer with no consumer; one more byte overruns
    ready = 1'b0; h0 = hs_log.size(); o0 = n_ovr;
    for (int i = 1; i <= CAP + 1; i++) send_frame(8'(i), 1'b1, 1'b0, s);
    wait_cycles(5);
    chk("ovr_count", n_ovr - o0, 1);
    chk("ovr_time", ovr_cyc - s, 744);
    chk("ovr_head_valid", valid, 1);
    chk("ovr_head_byte", byte_o, 8'h01);
    ready = 1'b1;
    wait_cycles(CAP + 3);
    chk("drain_count", hs_log.size() - h0, CAP);
    for (int i = 0; i < CAP; i++) chk("drain_order", hs_log[h0 + i], 8'(i + 1));
    chk("drain_empty", valid, 0);

    // Full buffer, consumer accepts in the push cycle: no overrun
    ready = 1'b0; h0 = hs_log.size(); o0 = n_ovr;
    for (int i = 0; i < CAP; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, s);
    send_frame(8'h20, 1'b1, 1'b1, s);
    wait_cycles(5);
    chk("same_cycle_no_ovr", n_ovr - o0, 0);
    chk("same_cycle_first", hs_log[h0], 8'h10);
    ready = 1'b1;
    wait_cycles(CAP + 3);
    chk("same_cycle_count", hs_log.size() - h0, CAP + 1);
    chk("same_cycle_last", hs_log[hs_log.size()-1], 8'h20);

    // Asynchronous reset in the middle of bit 4 of a 00 frame
    h0 = hs_log.size();
    rx = 1'b0;
    wait_cycles(4 * CLK_DIV + CLK_DIV / 2);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_valid", valid, 0);
    chk("async_byte", byte_o, 8'h00);
    chk("async_pulses", {30'd0, ferr, ovr}, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(350);
    rx = 1'b1;
    wait_cycles(2 * CLK_DIV);
    chk("resync_idle", busy, 0);
    chk("resync_no_byte", hs_log.size() - h0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, s);
    wait_cycles(5);
    chk("resync_ff_count", hs_log.size() - h0, 1);
    chk("resync_ff_byte", hs_log[hs_log.size()-1], 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
